// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: input handshake and registered BCD result bundle for bin2bcd_seq.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
);
    logic [BIN_W-1:0]    bin_in;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   lz_mask;
    logic                ovf;
    logic                out_valid;
    modport master (
        output bin_in, in_valid,
        input  in_ready, bcd_out, lz_mask, ovf, out_valid
    );
    modport slave (
        input  bin_in, in_valid,
        output in_ready, bcd_out, lz_mask, ovf, out_valid
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: shift-add-3 binary to packed BCD, one bit per clock, with leading-zero mask.
module bin2bcd_seq #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input logic          CLK,
    input logic          RST_N,
    bin2bcd_seq_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(10 ** DIGITS - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state, state_nx;
    logic [BIN_W-1:0] bin_sr;
    logic [BW-1:0]    bcd_acc, adj, res;
    logic [CW-1:0]    cnt;
    logic             ovf_pend;
    logic [DIGITS-1:0] lz_nx;
    always_ff @(posedge CLK)
        state <= !RST_N ? IDLE : state_nx;
    always_comb begin
        state_nx = state == IDLE  ? (bus.in_valid ? SHIFT : IDLE) :
                   state == SHIFT ? (cnt == CW'(1) ? DONE : SHIFT) : IDLE;
    end
    assign bus.in_ready = state == IDLE;
    always_comb begin
        adj = bcd_acc;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i+:4] = bcd_acc[4*i+:4] >= 4'd5 ? bcd_acc[4*i+:4] + 4'd3 : bcd_acc[4*i+:4];
        res = ovf_pend ? {DIGITS{4'h9}} : bcd_acc;
        lz_nx = '0;
        for (int i = 1; i < DIGITS; i++)
            lz_nx[i] = (res >> (4 * i)) == '0;
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bin_sr        <= '0;
            bcd_acc       <= '0;
            cnt           <= '0;
            ovf_pend      <= 1'b0;
            bus.bcd_out   <= '0;
            bus.lz_mask   <= {{(DIGITS-1){1'b1}}, 1'b0};
            bus.ovf       <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= state == DONE;
            if (state == IDLE && bus.in_valid) begin
                bin_sr   <= bus.bin_in;
                bcd_acc  <= '0;
                cnt      <= CW'(BIN_W);
                ovf_pend <= bus.bin_in > MAX_BIN;
            end
            if (state == SHIFT) begin
                {bcd_acc, bin_sr} <= {adj[BW-2:0], bin_sr, 1'b0};
                cnt               <= cnt - CW'(1);
            end
            if (state == DONE) begin
                bus.bcd_out <= res;
                bus.lz_mask <= lz_nx;
                bus.ovf     <= ovf_pend;
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed vectors with a queue scoreboard checked by an independent monitor.
module tb_bin2bcd_seq;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    typedef struct {
        logic [31:0] bcd;
        logic [7:0]  lz;
        logic        ovf;
        time         t;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] hold_bcd = 32'h0;
    logic [7:0]  hold_lz = 8'hFE;
    logic        hold_ovf = 1'b0;
    bit          prev_keep = 1'b0;
    time         prev_t = 0;

    bin2bcd_seq_if #(.BIN_W(27), .DIGITS(8)) bus ();
    bin2bcd_seq #(.BIN_W(27), .DIGITS(8)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("bcd_out", bus.bcd_out, e.bcd);
                    chk("lz_mask", bus.lz_mask, e.lz);
                    chk("ovf", bus.ovf, e.ovf);
                    chk("latency", $time - e.t, 285);
                    hold_bcd = e.bcd;
                    hold_lz  = e.lz;
                    hold_ovf = e.ovf;
                end
            end else begin
                chk("hold_bcd", bus.bcd_out, hold_bcd);
                chk("hold_lz", bus.lz_mask, hold_lz);
                chk("hold_ovf", bus.ovf, hold_ovf);
                if (sb.size() != 0) chk("busy_ready", bus.in_ready, 0);
            end
        end
    end

    task automatic send(input logic [26:0] v, input logic [31:0] eb, input logic [7:0] el,
                        input logic eo, input bit keep);
        int  n = 0;
        time t;
        @(posedge CLK); #1;
        while (!bus.in_ready && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!bus.in_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        bus.bin_in   = v;
        bus.in_valid = 1'b1;
        @(posedge CLK);
        t = $time;
        sb.push_back('{eb, el, eo, t});
        if (prev_keep) chk("throughput", t - prev_t, 290);
        prev_keep = keep;
        prev_t    = t;
        #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus.bin_in   = '0;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        chk("rst_bcd", bus.bcd_out, 0);
        chk("rst_lz", bus.lz_mask, 8'hFE);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        mon_en = 1'b1;

        send(27'd0,         32'h00000000, 8'hFE, 1'b0, 1'b0); drain();
        send(27'd12345678,  32'h12345678, 8'h00, 1'b0, 1'b0); drain();
        send(27'd1234,      32'h00001234, 8'hF0, 1'b0, 1'b0); drain();
        send(27'd99999999,  32'h99999999, 8'h00, 1'b0, 1'b0); drain();
        send(27'd100000000, 32'h99999999, 8'h00, 1'b1, 1'b0); drain();
        send(27'd5,         32'h00000005, 8'hFE, 1'b0, 1'b0); drain();
        send(27'h7FFFFFF,   32'h99999999, 8'h00, 1'b1, 1'b0); drain();

        send(27'd1000, 32'h00001000, 8'hF0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            bus.bin_in   = 27'd42;
            bus.in_valid = 1'b1;
            @(posedge CLK); #1;
            bus.in_valid = 1'b0;
        end
        drain();

        send(27'd99,  32'h00000099, 8'hFC, 1'b0, 1'b1);
        send(27'd100, 32'h00000100, 8'hF8, 1'b0, 1'b0);
        drain();

        send(27'd77777, 32'h00077777, 8'hE0, 1'b0, 1'b0);
        repeat (10) @(posedge CLK);
        #1;
        mon_en = 1'b0;
        RST_N  = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        sb.delete();
        hold_bcd = 32'h0;
        hold_lz  = 8'hFE;
        hold_ovf = 1'b0;
        @(negedge CLK);
        chk("abort_bcd", bus.bcd_out, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_out_valid", bus.out_valid, 0);
        @(posedge CLK); #1;
        mon_en = 1'b1;
        repeat (35) @(posedge CLK);
        send(27'd7, 32'h00000007, 8'hFE, 1'b0, 1'b0); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
